// File: rtl/relu_requant_pipe.sv
// relu_requant_pipe: two-stage per-channel ReLU, round, shift and saturate requantizer
module relu_requant_pipe #(
    parameter int CH    = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int SH_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_data,
    input  logic [SH_W-1:0]       shift,
    input  logic                  relu_en,
    input  logic                  round_en,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    output logic [CH-1:0]         sat_flag,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      sat_cnt
);
    localparam logic signed [IN_W:0] ONE   = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = -MAX_V - ONE;
    logic                  s1_v, s2_v, s1_relu, s1_sat;
    logic                  s2_ld, in_fire, out_fire;
    logic signed [IN_W:0]  rnd, lo_v;
    logic signed [IN_W:0]  ext  [CH];
    logic signed [IN_W:0]  s1_d [CH];
    logic signed [IN_W:0]  s1_q [CH];
    logic [CH-1:0]         hi, lw, s2_f;
    logic [CH*OUT_W-1:0]   s2_d;
    logic [CNT_W:0]        pop, cnt_sum;
    assign s2_ld     = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_ld;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_v && out_ready;
    assign out_valid = s2_v;
    // one guard bit above IN_W keeps the rounding add from wrapping positive values negative
    assign rnd  = (round_en && shift != '0) ? ONE << (shift - SH_W'(1)) : '0;
    assign lo_v = s1_relu ? '0 : MIN_V;
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            ext[k]  = (relu_en && in_data[k*IN_W + IN_W - 1]) ? '0
                    : {in_data[k*IN_W + IN_W - 1], in_data[k*IN_W +: IN_W]};
            s1_d[k] = (ext[k] + rnd) >>> shift;
        end
    end
    always_comb begin
        hi   = '0;
        lw   = '0;
        s2_f = '0;
        s2_d = '0;
        for (int k = 0; k < CH; k++) begin
            hi[k]   = s1_q[k] > MAX_V;
            lw[k]   = s1_q[k] < lo_v;
            s2_f[k] = s1_sat && (hi[k] || lw[k]);
            s2_d[k*OUT_W +: OUT_W] = (s1_sat && hi[k]) ? MAX_V[OUT_W-1:0]
                                   : (s1_sat && lw[k]) ? lo_v[OUT_W-1:0]
                                   : s1_q[k][OUT_W-1:0];
        end
    end
    always_comb begin
        pop = '0;
        for (int k = 0; k < CH; k++)
            pop = pop + (CNT_W+1)'(sat_flag[k]);
        cnt_sum = {1'b0, sat_cnt} + pop;
    end
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_q    <= s1_d;
            s1_relu <= relu_en;
            s1_sat  <= sat_en;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            out_data <= '0;
            sat_flag <= '0;
            sat_cnt  <= '0;
        end else begin
            s1_v <= in_fire || (s1_v && !s2_ld);
            if (s2_ld)
                s2_v <= s1_v;
            if (s2_ld && s1_v) begin
                out_data <= s2_d;
                sat_flag <= s2_f;
            end
            sat_cnt <= cnt_clr ? '0 : !out_fire ? sat_cnt : cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_relu_requant_pipe.sv
// tb_relu_requant_pipe: scoreboard bench for relu_requant_pipe
module tb_relu_requant_pipe;
    localparam int CH = 4, IN_W = 32, OUT_W = 8, SH_W = 5, CNT_W = 5;
    localparam int CMAX = (1 << CNT_W) - 1;
    typedef struct packed {
        logic [CH*OUT_W-1:0] d;
        logic [CH-1:0]       f;
    } exp_t;
    logic                clk = 0, rst_n = 0, in_valid = 0, relu_en = 0, round_en = 0, sat_en = 0;
    logic                out_ready = 1, cnt_clr = 0, in_ready, out_valid;
    logic [CH*IN_W-1:0]  in_data = '0;
    logic [SH_W-1:0]     shift = '0;
    logic [CH*OUT_W-1:0] out_data;
    logic [CH-1:0]       sat_flag;
    logic [CNT_W-1:0]    sat_cnt;
    exp_t q[$];
    exp_t mon_e, last;
    int   checks = 0, errors = 0, exp_cnt = 0, npop;
    bit   stall = 0, rnd_done = 0;

    always #5 clk = ~clk;

    relu_requant_pipe #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .shift(shift), .relu_en(relu_en), .round_en(round_en), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag),
        .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [CH*IN_W-1:0] d, input int sh, input bit rl, rn, st);
        exp_t e;
        longint x, hv, lv;
        logic signed [IN_W-1:0] xs;
        hv = (longint'(1) << (OUT_W-1)) - 1;
        lv = rl ? 0 : -hv - 1;
        for (int k = 0; k < CH; k++) begin
            xs = d[k*IN_W +: IN_W];
            x = xs;
            if (rl && x < 0) x = 0;
            if (rn && sh > 0) x += longint'(1) << (sh - 1);
            x = x >>> sh;
            e.f[k] = 1'b0;
            if (st && x > hv) begin x = hv; e.f[k] = 1'b1; end
            else if (st && x < lv) begin x = lv; e.f[k] = 1'b1; end
            e.d[k*OUT_W +: OUT_W] = x[OUT_W-1:0];
        end
        return e;
    endfunction

    // called half a step after a rising edge; returns likewise
    task automatic send(input logic [CH*IN_W-1:0] d, input logic [SH_W-1:0] sh, input bit rl, rn, st,
                        input logic [CH*OUT_W-1:0] ed, input logic [CH-1:0] ef);
        int n = 0;
        in_data = d; shift = sh; relu_en = rl; round_en = rn; sat_en = st; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        else q.push_back({ed, ef});
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1;
        @(posedge clk); #1;
        cnt_clr = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = 0;
            stall = 0;
        end else begin
            check("sat_cnt", sat_cnt, exp_cnt);
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_data, sat_flag}, last);
            end
            stall = out_valid && !out_ready;
            last = {out_data, sat_flag};
            npop = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_beat", out_valid, 0);
                else begin
                    mon_e = q.pop_front();
                    check("out_data", out_data, mon_e.d);
                    check("sat_flag", sat_flag, mon_e.f);
                    npop = $countones(mon_e.f);
                end
            end
            exp_cnt = cnt_clr ? 0 : (exp_cnt + npop > CMAX ? CMAX : exp_cnt + npop);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk); #1;
        send({32'h7FFFFFFF, 32'h01000000, 32'hFFFF0000, 32'h00123456}, 16, 1, 0, 1, 32'h7F7F0012, 4'b1100);
        @(negedge clk);
        check("lat_early", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        drain();
        send({32'hFF000000, 32'h01000000, 32'h00123456, 32'hFFFF0000}, 16, 0, 0, 1, 32'h807F12FF, 4'b1100);
        send({32'h00FF8000, 32'hFFFF0000, 32'h00123456, 32'h01000000}, 16, 1, 0, 0, 32'hFF001200, 4'b0000);
        send({32'h00018000, 32'h7FFFFFFF, 32'h00007FFF, 32'h00008000}, 16, 1, 1, 1, 32'h027F0001, 4'b0100);
        send({32'hFFFFF800, 32'h00000017, 32'hFFFFFFF7, 32'hFFFFFFF8}, 4, 0, 1, 1, 32'h8001FF00, 4'b0000);
        send({32'hFFFFFF7F, 32'hFFFFFF80, 32'h00000080, 32'h0000007F}, 0, 0, 1, 1, 32'h80807F7F, 4'b1010);
        drain();
        pulse_clr();
        send({4{32'h01000000}}, 16, 1, 0, 1, 32'h7F7F7F7F, 4'b1111);
        drain();
        check("cnt_plus4", sat_cnt, 4);
        for (int i = 0; i < 8; i++)
            send({4{32'h01000000}}, 16, 1, 0, 1, 32'h7F7F7F7F, 4'b1111);
        drain();
        check("cnt_stick", sat_cnt, CMAX);
        send({4{32'h01000000}}, 16, 1, 0, 1, 32'h7F7F7F7F, 4'b1111);
        @(posedge clk); #1;
        cnt_clr = 1;
        @(posedge clk); #1;
        cnt_clr = 0;
        @(negedge clk);
        check("clr_prio", sat_cnt, 0);
        drain();
        out_ready = 0;
        fork
            begin
                send({32'h7FFFFFFF, 32'h01000000, 32'hFFFF0000, 32'h00123456}, 16, 1, 0, 1, 32'h7F7F0012, 4'b1100);
                send({32'hFF000000, 32'h01000000, 32'h00123456, 32'hFFFF0000}, 16, 0, 0, 1, 32'h807F12FF, 4'b1100);
                send({32'h00018000, 32'h7FFFFFFF, 32'h00007FFF, 32'h00008000}, 16, 1, 1, 1, 32'h027F0001, 4'b0100);
                send({32'hFFFFFF7F, 32'hFFFFFF80, 32'h00000080, 32'h0000007F}, 0, 0, 1, 1, 32'h80807F7F, 4'b1010);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        drain();
        check("bp_cnt", sat_cnt, 7);
        send({4{32'h01000000}}, 16, 1, 0, 1, 32'h7F7F7F7F, 4'b1111);
        send({32'hFF000000, 32'h01000000, 32'h00123456, 32'hFFFF0000}, 16, 0, 0, 1, 32'h807F12FF, 4'b1100);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cnt", sat_cnt, 0);
        check("mid_rst_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [CH*IN_W-1:0] d;
                    logic signed [IN_W-1:0] v;
                    int sh;
                    bit rl, rn, st;
                    exp_t e;
                    for (int k = 0; k < CH; k++) begin
                        v = $urandom;
                        v = v >>> $urandom_range(0, 31);
                        d[k*IN_W +: IN_W] = v;
                    end
                    sh = $urandom_range(0, 31);
                    rl = $urandom_range(0, 1) == 1;
                    rn = $urandom_range(0, 1) == 1;
                    st = $urandom_range(0, 3) != 0;
                    e = model(d, sh, rl, rn, st);
                    send(d, SH_W'(sh), rl, rn, st, e.d, e.f);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = $urandom_range(0, 3) != 0;
                    cnt_clr = $urandom_range(0, 15) == 0;
                end
            end
        join
        out_ready = 1;
        cnt_clr = 0;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_requant_pipe.md
RELU_REQUANT_PIPE -- requirements
Module: relu_requant_pipe

Interface
REQ-001 SHALL have parameter CH, default 4: number of parallel channels per beat.
REQ-002 SHALL have parameter IN_W, default 32: signed accumulator width per channel.
REQ-003 SHALL have parameter OUT_W, default 8: signed output width per channel.
REQ-004 SHALL have parameter SH_W, default 5: shift-amount width; legal shift range 0..IN_W-1.
REQ-005 SHALL have parameter CNT_W, default 16: saturation-event counter width.
REQ-006 Ports, in this order:
- clk  in  1  -- sole clock, rising edge.
- rst_n  in  1  -- synchronous, active-low reset.
- in_valid  in  1  -- input beat valid.
- in_ready  out  1  -- block can accept a beat.
- in_data  in  CH*IN_W  -- channel k at bits [k*IN_W +: IN_W], two's complement.
- shift  in  SH_W  -- arithmetic right-shift amount, sampled with the beat.
- relu_en  in  1  -- clamp negatives to 0, sampled with the beat.
- round_en  in  1  -- round half-up before shift, sampled with the beat.
- sat_en  in  1  -- saturate (1) or wrap-truncate (0), sampled with the beat.
- out_valid  out  1  -- output beat valid.
- out_ready  in  1  -- downstream accepts a beat.
- out_data  out  CH*OUT_W  -- channel k at bits [k*OUT_W +: OUT_W].
- sat_flag  out  CH  -- per-channel saturation indicator, aligned with out_data.
- cnt_clr  in  1  -- synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  -- total saturated channel results since reset or clear.

Function
REQ-007 An input beat SHALL transfer on a rising edge with in_valid=1 and in_ready=1; an output beat SHALL transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-008 The datapath SHALL be a 2-stage register pipeline: S1 = ReLU + round + shift; S2 = saturate/truncate, registered onto out_data.
REQ-009 Latency SHALL be 2 cycles from the input transfer edge to out_valid=1 when out_ready stays 1; throughput SHALL be 1 beat per cycle.
REQ-010 Each stage SHALL load when it is empty or when its content moves on in the same cycle; in_ready SHALL equal !S1_valid || (!S2_valid || out_ready).
REQ-011 When out_ready=0, out_data, sat_flag and out_valid SHALL hold stable; no beat SHALL be lost, duplicated or reordered.
REQ-012 ReLU: if relu_en=1 and x<0, x SHALL become 0; if relu_en=0, the signed value SHALL pass through unchanged.
REQ-013 Rounding: if round_en=1 and shift>0, 2^(shift-1) SHALL be added before the shift.
- Internal width SHALL be IN_W+1, so 0x7FFF_FFFF does not overflow.
- Shift SHALL be arithmetic, i.e. sign-extending.
REQ-014 Saturation with sat_en=1:
- relu_en=1: result SHALL clamp to [0, 2^(OUT_W-1)-1].
- relu_en=0: result SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- sat_flag[k] SHALL be 1 when clamping occurred.
REQ-015 With sat_en=0, the output SHALL be the low OUT_W bits of the shifted value and sat_flag SHALL be 0.
REQ-016 sat_cnt SHALL increase by popcount(sat_flag) on each output transfer edge.
- Stalled beats SHALL NOT count.
- It SHALL stick at all-ones and never wrap.
REQ-017 cnt_clr=1 SHALL set sat_cnt to 0 on that edge; cnt_clr SHALL take priority over a simultaneous increment.
REQ-018 A shift value >= IN_W is illegal; the output for it is undefined, but the handshake SHALL remain correct.

Reset
REQ-019 While rst_n=0 at a rising edge, both stage valids, out_valid, out_data, sat_flag and sat_cnt SHALL become 0.
REQ-020 in_ready SHALL be 1 on the first cycle after rst_n returns to 1.
REQ-021 A reset mid-stream SHALL discard all in-flight beats with no partial output.

Verification
REQ-022 Passthrough: x=0x0012_3456, shift=16, relu_en=1, round_en=0, sat_en=1, out_ready=1 -> out=0x12 two cycles later, sat_flag=0.
REQ-023 Negative inputs, x=0xFFFF_0000, shift=16:
- relu_en=1 -> 0x00.
- relu_en=0, round_en=0 -> 0xFF.
REQ-024 Overflow: x=0x0100_0000, shift=16, relu_en=1:
- sat_en=1 -> 0x7F, sat_flag=1, sat_cnt +1.
- sat_en=0 -> 0x00, sat_flag=0.
- All 4 channels saturating -> sat_cnt +4.
REQ-025 Rounding, shift=16, round_en=1:
- x=0x0000_8000 -> 0x01.
- x=0x0000_7FFF -> 0x00.
- x=0x7FFF_FFFF, sat_en=1 -> 0x7F with no internal wrap.
REQ-026 Back-pressure: 4 beats offered back-to-back, out_ready=0 for 3 cycles:
- in_ready drops after 2 beats are held.
- After release, all 4 beats emerge in order, unchanged.
- sat_cnt counts each beat once.
REQ-027 Reset and clear:
- rst_n=0 for one edge with 2 beats in flight -> out_valid=0, sat_cnt=0 next cycle; no stale beat appears afterwards.
- cnt_clr coinciding with a saturating output transfer -> sat_cnt=0.
